// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences instruction fetches against an external PC
// register. It drives the next PC, issues instruction-memory requests at the
// current PC, hands fetched words to decode (buffering one while decode
// stalls), and applies branch/jump redirects. A redirect that arrives while a
// fetch is still waiting for its ack is remembered and applied when that ack
// comes back.
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] pcnext,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        core_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        redirect_pending_q, redirect_pending_d;
   logic [31:0] pending_target_q, pending_target_d;
   logic [31:0] instr_buf_q, instr_buf_d;

   logic [31:0] redirect_aligned;
   logic        redirect_unaligned;
   logic [31:0] pc_plus4;

   // Redirect targets are forced to word alignment; low bits only flag.
   assign redirect_aligned   = {redirect_target[31:2], 2'b00};
   assign redirect_unaligned = |redirect_target[1:0];

   // Sequential increment wraps naturally at 2^32.
   assign pc_plus4 = pc + 32'd4;

   // The fetch address always tracks the external PC register, so it stays
   // stable while a request waits because pcnext holds pc in that case.
   assign imem_addr = pc;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect bookkeeping and the decode-stall instruction buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_pending_q <= 1'b0;
         pending_target_q   <= '0;
         instr_buf_q        <= '0;
      end else begin
         redirect_pending_q <= redirect_pending_d;
         pending_target_q   <= pending_target_d;
         instr_buf_q        <= instr_buf_d;
      end
   end

   // Next-state and register-update decisions.
   always_comb begin
      state_d            = state_q;
      redirect_pending_d = redirect_pending_q;
      pending_target_d   = pending_target_q;
      instr_buf_d        = instr_buf_q;
      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  // Outstanding fetch completes now; redirect applies directly.
                  redirect_pending_d = 1'b0;
               end else begin
                  // Newest redirect wins while the fetch is still in flight.
                  redirect_pending_d = 1'b1;
                  pending_target_d   = redirect_aligned;
               end
            end else if (imem_ack) begin
               if (redirect_pending_q) begin
                  redirect_pending_d = 1'b0;
               end else if (core_stall) begin
                  instr_buf_d = imem_rdata;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_valid || !core_stall) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // Output decode: next PC, request, delivered instruction, misalign flag.
   always_comb begin
      pcnext      = pc;
      imem_req    = 1'b0;
      instr       = '0;
      instr_valid = 1'b0;
      misaligned  = 1'b0;
      case (state_q)
         BOOT: begin
            pcnext = RESET_VECTOR;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (redirect_valid) begin
               misaligned = redirect_unaligned;
               if (imem_ack) begin
                  pcnext = redirect_aligned;
               end
            end else if (imem_ack) begin
               if (redirect_pending_q) begin
                  pcnext = pending_target_q;
               end else if (!core_stall) begin
                  instr       = imem_rdata;
                  instr_valid = 1'b1;
                  pcnext      = pc_plus4;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               misaligned = redirect_unaligned;
               pcnext     = redirect_aligned;
            end else begin
               instr       = instr_buf_q;
               instr_valid = 1'b1;
               if (!core_stall) begin
                  pcnext = pc_plus4;
               end
            end
         end
         default: begin
            pcnext = RESET_VECTOR;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by randomized traffic,
// checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc;
   logic [31:0] pcnext;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        core_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        misaligned;

   int checks = 0;
   int failures = 0;

   // model state
   bit          m_boot = 1'b1;
   bit          m_hold = 1'b0;
   logic [31:0] m_buf  = '0;
   bit          m_pend = 1'b0;
   logic [31:0] m_ptgt = '0;

   // last sampled DUT outputs, for directed checks
   logic [31:0] s_addr, s_pcn, s_instr;
   logic        s_req, s_val, s_mis;

   fetch_sequencer #(.RESET_VECTOR(RV)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc              (pc),
      .pcnext          (pcnext),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .core_stall      (core_stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .instr           (instr),
      .instr_valid     (instr_valid),
      .misaligned      (misaligned)
   );

   always #5 clk = ~clk;

   // external pc_register
   always @(posedge clk) pc <= pcnext;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Asserts reset between clock edges, checks the immediate output values,
   // then releases shortly after a rising edge so the BOOT cycle is observable.
   task automatic apply_reset();
      rst = 1'b1;
      #1;
      chk("rst_pcnext", pcnext, RV);
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", instr_valid, 1'b0);
      chk1("rst_mis", misaligned, 1'b0);
      chk("rst_instr", instr, 32'h0);
      imem_ack = 1'b0;
      core_stall = 1'b0;
      redirect_valid = 1'b0;
      m_boot = 1'b1;
      m_hold = 1'b0;
      m_buf  = '0;
      m_pend = 1'b0;
      m_ptgt = '0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // One clock cycle: drive inputs after the falling edge, check outputs against
   // the model, then advance the model across the rising edge.
   task automatic step(input logic ack, input logic stall, input logic rv,
                       input logic [31:0] rt, input logic [31:0] salt);
      logic [31:0] e_pcn, e_instr, rdata, tgt;
      logic        e_req, e_val, e_mis;
      bit          n_hold, n_pend;
      logic [31:0] n_buf, n_ptgt;
      @(negedge clk);
      rdata           = word_of(pc) ^ salt;
      imem_ack        = ack;
      core_stall      = stall;
      redirect_valid  = rv;
      redirect_target = rt;
      imem_rdata      = rdata;
      #1;
      tgt     = rt & 32'hFFFF_FFFC;
      n_hold  = m_hold;
      n_buf   = m_buf;
      n_pend  = m_pend;
      n_ptgt  = m_ptgt;
      e_req   = 1'b0;
      e_val   = 1'b0;
      e_mis   = 1'b0;
      e_instr = '0;
      e_pcn   = pc;
      if (m_boot) begin
         e_pcn = RV;
      end else if (m_hold) begin
         if (rv) begin
            e_mis  = (rt % 4) != 0;
            e_pcn  = tgt;
            n_hold = 1'b0;
         end else begin
            e_val   = 1'b1;
            e_instr = m_buf;
            if (!stall) begin
               e_pcn  = pc + 32'd4;
               n_hold = 1'b0;
            end
         end
      end else begin
         e_req = 1'b1;
         if (rv) begin
            e_mis = (rt % 4) != 0;
            if (ack) begin
               e_pcn  = tgt;
               n_pend = 1'b0;
            end else begin
               n_pend = 1'b1;
               n_ptgt = tgt;
            end
         end else if (ack) begin
            if (m_pend) begin
               e_pcn  = m_ptgt;
               n_pend = 1'b0;
            end else if (stall) begin
               n_hold = 1'b1;
               n_buf  = rdata;
            end else begin
               e_val   = 1'b1;
               e_instr = rdata;
               e_pcn   = pc + 32'd4;
            end
         end
      end
      chk("pcnext", pcnext, e_pcn);
      chk("imem_addr", imem_addr, pc);
      chk1("imem_req", imem_req, e_req);
      chk1("instr_valid", instr_valid, e_val);
      chk1("misaligned", misaligned, e_mis);
      if (e_val) chk("instr", instr, e_instr);
      s_addr  = imem_addr;
      s_pcn   = pcnext;
      s_instr = instr;
      s_req   = imem_req;
      s_val   = instr_valid;
      s_mis   = misaligned;
      @(posedge clk);
      m_boot = 1'b0;
      m_hold = n_hold;
      m_buf  = n_buf;
      m_pend = n_pend;
      m_ptgt = n_ptgt;
   endtask

   initial begin
      logic [31:0] rt;
      int unsigned r;

      #2;
      apply_reset();

      // boot cycle, then sequential fetch with immediate acks
      step(0, 0, 0, 0, 0);
      chk1("boot_req", s_req, 1'b0);
      chk("boot_pcnext", s_pcn, RV);
      step(1, 0, 0, 0, 0);
      chk("seq_addr0", s_addr, 32'h100);
      chk1("seq_req0", s_req, 1'b1);
      chk1("seq_val0", s_val, 1'b1);
      chk("seq_instr0", s_instr, word_of(32'h100));
      step(1, 0, 0, 0, 0);
      chk("seq_addr1", s_addr, 32'h104);
      chk("seq_instr1", s_instr, word_of(32'h104));
      step(1, 0, 0, 0, 0);
      chk("seq_addr2", s_addr, 32'h108);
      chk("seq_instr2", s_instr, word_of(32'h108));

      // decode stall at 0x104
      #2;
      apply_reset();
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("stall_addr", s_addr, 32'h104);
      chk1("stall_val", s_val, 1'b0);
      chk("stall_pcn", s_pcn, 32'h104);
      for (int k = 0; k < 2; k++) begin
         step(0, 1, 0, 0, 0);
         chk1("hold_req", s_req, 1'b0);
         chk1("hold_val", s_val, 1'b1);
         chk("hold_instr", s_instr, word_of(32'h104));
         chk("hold_pcn", s_pcn, 32'h104);
      end
      step(0, 0, 0, 0, 0);
      chk1("hold_rel_val", s_val, 1'b1);
      chk("hold_rel_pcn", s_pcn, 32'h108);

      // redirect while the fetch at 0x108 waits for its ack
      step(0, 0, 1, 32'h200, 0);
      chk("redir_addr", s_addr, 32'h108);
      chk("redir_pcn", s_pcn, 32'h108);
      step(0, 0, 0, 0, 0);
      chk("redir_wait_pcn", s_pcn, 32'h108);
      step(1, 0, 0, 0, 0);
      chk1("redir_ack_val", s_val, 1'b0);
      chk("redir_ack_pcn", s_pcn, 32'h200);

      // misaligned redirect with ack, then address wrap
      step(1, 0, 1, 32'h203, 0);
      chk("mis_addr", s_addr, 32'h200);
      chk1("mis_flag", s_mis, 1'b1);
      chk("mis_pcn", s_pcn, 32'h200);
      step(0, 0, 0, 0, 0);
      chk1("mis_clear", s_mis, 1'b0);
      chk("mis_next_addr", s_addr, 32'h200);
      step(1, 0, 1, 32'hFFFF_FFFC, 0);
      chk("wrap_redir_pcn", s_pcn, 32'hFFFF_FFFC);
      step(1, 0, 0, 0, 0);
      chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
      chk("wrap_pcn", s_pcn, 32'h0);
      step(0, 0, 0, 0, 0);
      chk("wrap_next_addr", s_addr, 32'h0);

      // asynchronous reset in the middle of HOLD
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk1("pre_rst_hold_val", s_val, 1'b1);
      @(negedge clk);
      imem_ack = 1'b1;
      core_stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_target = 32'h203;
      #1;
      chk1("pre_rst_mis", misaligned, 1'b1);
      #1;
      apply_reset();
      step(0, 0, 0, 0, 0);
      chk1("rst_boot_req", s_req, 1'b0);
      step(0, 0, 0, 0, 0);
      chk("rst_restart_addr", s_addr, RV);
      chk1("rst_restart_req", s_req, 1'b1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            #2;
            apply_reset();
         end else begin
            case ($urandom_range(0, 3))
               0: rt = $urandom;
               1: rt = $urandom & 32'h0000_0FFC;
               2: rt = 32'hFFFF_FFFC;
               default: rt = 32'hFFFF_FFFF;
            endcase
            step(logic'($urandom_range(0, 99) < 50),
                 logic'($urandom_range(0, 99) < 35),
                 logic'($urandom_range(0, 99) < 12),
                 rt, $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
